// File: rtl/e_stage_reg.sv
// rtl/e_stage_reg.sv - D/E pipeline register with bubble insertion, Tnew countdown and operand forwarding
module e_stage_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] D_PC,
   input  logic [31:0] D_instr,
   input  logic [31:0] D_rs_data,
   input  logic [31:0] D_rt_data,
   input  logic [31:0] D_imm,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic [4:0]  D_A3,
   input  logic [2:0]  D_ALUOp,
   input  logic        D_ALUSrc,
   input  logic        D_RegWrite,
   input  logic [1:0]  D_Tnew,
   input  logic [4:0]  M_A3,
   input  logic [4:0]  W_A3,
   input  logic        M_RegWrite,
   input  logic        W_RegWrite,
   input  logic [31:0] M_data,
   input  logic [31:0] W_data,
   output logic [31:0] E_A,
   output logic [31:0] E_B,
   output logic [2:0]  E_ALUOp,
   output logic [31:0] E_rt_fwd,
   output logic [31:0] E_PC,
   output logic [31:0] E_instr,
   output logic [4:0]  E_A3,
   output logic        E_RegWrite,
   output logic [1:0]  E_Tnew,
   output logic        E_valid,
   output logic [15:0] bubble_cnt
);

   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] imm;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        alusrc;
   logic [31:0] rs_fwd;
   logic [31:0] rt_fwd;

   // Stage register: reset clears everything, stall loads a NOP bubble, otherwise capture D.
   // Tnew keeps counting down through bubbles so an in-flight result age stays meaningful.
   always_ff @(posedge clk) begin
      if (!reset) begin
         E_PC       <= 32'd0;
         E_instr    <= 32'd0;
         rs_data    <= 32'd0;
         rt_data    <= 32'd0;
         imm        <= 32'd0;
         rs         <= 5'd0;
         rt         <= 5'd0;
         E_A3       <= 5'd0;
         E_ALUOp    <= 3'd0;
         alusrc     <= 1'b0;
         E_RegWrite <= 1'b0;
         E_Tnew     <= 2'd0;
         E_valid    <= 1'b0;
         bubble_cnt <= 16'd0;
      end else if (stall) begin
         E_PC       <= 32'd0;
         E_instr    <= 32'd0;
         rs_data    <= 32'd0;
         rt_data    <= 32'd0;
         imm        <= 32'd0;
         rs         <= 5'd0;
         rt         <= 5'd0;
         E_A3       <= 5'd0;
         E_ALUOp    <= 3'd0;
         alusrc     <= 1'b0;
         E_RegWrite <= 1'b0;
         E_Tnew     <= (E_Tnew != 2'd0) ? E_Tnew - 2'd1 : 2'd0;
         E_valid    <= 1'b0;
         bubble_cnt <= bubble_cnt + 16'd1;
      end else begin
         E_PC       <= D_PC;
         E_instr    <= D_instr;
         rs_data    <= D_rs_data;
         rt_data    <= D_rt_data;
         imm        <= D_imm;
         rs         <= D_rs;
         rt         <= D_rt;
         E_A3       <= D_A3;
         E_ALUOp    <= D_ALUOp;
         alusrc     <= D_ALUSrc;
         E_RegWrite <= D_RegWrite;
         E_Tnew     <= D_Tnew;
         E_valid    <= 1'b1;
      end
   end

   // Forwarding mux: M beats W, and register 0 never takes a forwarded value.
   always_comb begin
      rs_fwd = rs_data;
      if (rs != 5'd0 && rs == M_A3 && M_RegWrite)
         rs_fwd = M_data;
      else if (rs != 5'd0 && rs == W_A3 && W_RegWrite)
         rs_fwd = W_data;

      rt_fwd = rt_data;
      if (rt != 5'd0 && rt == M_A3 && M_RegWrite)
         rt_fwd = M_data;
      else if (rt != 5'd0 && rt == W_A3 && W_RegWrite)
         rt_fwd = W_data;
   end

   // ALU operand selection; the immediate goes through unshifted since the ALU handles lui.
   always_comb begin
      E_A      = rs_fwd;
      E_B      = alusrc ? imm : rt_fwd;
      E_rt_fwd = rt_fwd;
   end

endmodule

// File: tb/tb_e_stage_reg.sv
// tb/tb_e_stage_reg.sv - randomized self-checking bench for e_stage_reg against a behavioural model
module tb_e_stage_reg;

   logic        clk = 1'b0;
   logic        reset, stall;
   logic [31:0] D_PC, D_instr, D_rs_data, D_rt_data, D_imm;
   logic [4:0]  D_rs, D_rt, D_A3;
   logic [2:0]  D_ALUOp;
   logic        D_ALUSrc, D_RegWrite;
   logic [1:0]  D_Tnew;
   logic [4:0]  M_A3, W_A3;
   logic        M_RegWrite, W_RegWrite;
   logic [31:0] M_data, W_data;
   logic [31:0] E_A, E_B, E_rt_fwd, E_PC, E_instr;
   logic [2:0]  E_ALUOp;
   logic [4:0]  E_A3;
   logic        E_RegWrite, E_valid;
   logic [1:0]  E_Tnew;
   logic [15:0] bubble_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc, instr, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, a3;
      logic [2:0]  aluop;
      logic        alusrc, regwrite, valid;
      int          tnew;
   } stage_t;

   stage_t      m;
   int unsigned m_bcnt;

   always #5 clk = ~clk;

   e_stage_reg dut (
      .clk(clk), .reset(reset), .stall(stall),
      .D_PC(D_PC), .D_instr(D_instr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .D_imm(D_imm),
      .D_rs(D_rs), .D_rt(D_rt), .D_A3(D_A3), .D_ALUOp(D_ALUOp), .D_ALUSrc(D_ALUSrc),
      .D_RegWrite(D_RegWrite), .D_Tnew(D_Tnew),
      .M_A3(M_A3), .W_A3(W_A3), .M_RegWrite(M_RegWrite), .W_RegWrite(W_RegWrite),
      .M_data(M_data), .W_data(W_data),
      .E_A(E_A), .E_B(E_B), .E_ALUOp(E_ALUOp), .E_rt_fwd(E_rt_fwd), .E_PC(E_PC), .E_instr(E_instr),
      .E_A3(E_A3), .E_RegWrite(E_RegWrite), .E_Tnew(E_Tnew), .E_valid(E_valid), .bubble_cnt(bubble_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] stored);
      if (r == 0) return stored;
      if (M_RegWrite && M_A3 == r) return M_data;
      if (W_RegWrite && W_A3 == r) return W_data;
      return stored;
   endfunction

   // Expected effect of the coming clock edge, from the current inputs.
   task automatic model_edge();
      stage_t z;
      z = '{default: 0};
      if (!reset) begin
         m = z;
         m_bcnt = 0;
      end else if (stall) begin
         z.tnew = (m.tnew > 0) ? m.tnew - 1 : 0;
         m = z;
         m_bcnt = (m_bcnt + 1) % 65536;
      end else begin
         m.pc = D_PC; m.instr = D_instr; m.rs_data = D_rs_data; m.rt_data = D_rt_data;
         m.imm = D_imm; m.rs = D_rs; m.rt = D_rt; m.a3 = D_A3; m.aluop = D_ALUOp;
         m.alusrc = D_ALUSrc; m.regwrite = D_RegWrite; m.tnew = int'(D_Tnew); m.valid = 1'b1;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all();
      logic [31:0] exp_b;
      #1;
      exp_b = m.alusrc ? m.imm : fwd(m.rt, m.rt_data);
      check("E_PC", E_PC, m.pc);
      check("E_instr", E_instr, m.instr);
      check("E_A3", {27'd0, E_A3}, {27'd0, m.a3});
      check("E_RegWrite", {31'd0, E_RegWrite}, {31'd0, m.regwrite});
      check("E_ALUOp", {29'd0, E_ALUOp}, {29'd0, m.aluop});
      check("E_Tnew", {30'd0, E_Tnew}, m.tnew);
      check("E_valid", {31'd0, E_valid}, {31'd0, m.valid});
      check("bubble_cnt", {16'd0, bubble_cnt}, m_bcnt);
      check("E_A", E_A, fwd(m.rs, m.rs_data));
      check("E_B", E_B, exp_b);
      check("E_rt_fwd", E_rt_fwd, fwd(m.rt, m.rt_data));
   endtask

   task automatic rand_d();
      D_PC = $urandom; D_instr = $urandom; D_rs_data = $urandom; D_rt_data = $urandom;
      D_imm = $urandom; D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
      D_A3 = 5'($urandom); D_ALUOp = 3'($urandom); D_ALUSrc = 1'($urandom);
      D_RegWrite = 1'($urandom); D_Tnew = 2'($urandom);
   endtask

   task automatic rand_fw();
      M_A3 = 5'($urandom_range(0, 3)); W_A3 = 5'($urandom_range(0, 3));
      M_RegWrite = 1'($urandom); W_RegWrite = 1'($urandom);
      M_data = $urandom; W_data = $urandom;
   endtask

   initial begin
      m = '{default: 0};
      m_bcnt = 0;
      rand_d();
      M_A3 = 0; W_A3 = 0; M_RegWrite = 0; W_RegWrite = 0; M_data = 0; W_data = 0;
      reset = 1'b0; stall = 1'b0;
      D_PC = 32'hDEAD_0000;
      step(); step();
      check_all();
      check("reset_E_A", E_A, 32'd0);
      check("reset_E_B", E_B, 32'd0);

      // first capture after reset
      reset = 1'b1; stall = 1'b0;
      D_PC = 32'h3000; D_ALUOp = 3'b000; D_rs_data = 5; D_rt_data = 7; D_ALUSrc = 1'b0;
      D_rs = 5'd1; D_rt = 5'd2;
      step();
      check_all();
      check("first_E_PC", E_PC, 32'h3000);
      check("first_E_A", E_A, 32'd5);
      check("first_E_B", E_B, 32'd7);
      check("first_E_valid", {31'd0, E_valid}, 32'd1);

      // M beats W when both match
      D_rs = 5'd8; D_rt = 5'd0; D_rt_data = 32'd0; D_ALUSrc = 1'b0;
      step();
      M_A3 = 5'd8; M_RegWrite = 1'b1; M_data = 32'h11;
      W_A3 = 5'd8; W_RegWrite = 1'b1; W_data = 32'h22;
      check_all();
      check("prio_E_A", E_A, 32'h11);

      // register 0 never forwarded
      M_A3 = 5'd0; M_RegWrite = 1'b1; M_data = 32'hFF;
      check_all();
      check("zero_E_rt_fwd", E_rt_fwd, 32'd0);

      // three bubbles
      stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         check_all();
         check("bub_valid", {31'd0, E_valid}, 32'd0);
         check("bub_regwrite", {31'd0, E_RegWrite}, 32'd0);
      end
      check("bub_cnt3", {16'd0, bubble_cnt}, 32'd3);

      // immediate operand and Tnew countdown through bubbles
      stall = 1'b0;
      D_ALUSrc = 1'b1; D_imm = 32'h0000ABCD; D_ALUOp = 3'b100; D_Tnew = 2'd2;
      step();
      check_all();
      check("imm_E_B", E_B, 32'h0000ABCD);
      check("tnew_0", {30'd0, E_Tnew}, 32'd2);
      stall = 1'b1;
      step(); check("tnew_1", {30'd0, E_Tnew}, 32'd1);
      step(); check("tnew_2", {30'd0, E_Tnew}, 32'd0);
      step(); check("tnew_3", {30'd0, E_Tnew}, 32'd0);
      check_all();

      // reset wins over stall
      reset = 1'b0; stall = 1'b1;
      step();
      check_all();
      check("rst_stall_cnt", {16'd0, bubble_cnt}, 32'd0);
      check("rst_stall_valid", {31'd0, E_valid}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
         stall = ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0;
         rand_d();
         step();
         rand_fw();
         check_all();
      end

      // bubble counter wraparound
      reset = 1'b1; stall = 1'b1;
      while (m_bcnt != 32'hFFFF) step();
      check_all();
      step();
      check_all();
      check("wrap_cnt", {16'd0, bubble_cnt}, 32'd0);
      stall = 1'b0;
      rand_d();
      step();
      check_all();
      check("hold_cnt", {16'd0, bubble_cnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
